// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Used by sram_arb_rr2 and sram_arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } arb_state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  // Every SRAM strobe is active-low, so "inactive" is a logic one.
  localparam logic STROBE_OFF = 1'b1;

  // Latched control part of a transfer.
  typedef struct packed {
    logic       port;
    logic       write;
    logic [1:0] be;
  } xfer_ctl_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way request picker. Round-robin by default; strict port-0 priority
// when SRAM_ARB_FIXED_PRIO_EN is defined.
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_next
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic ptr_unused;
  assign ptr_unused = ptr;
  assign ptr_next   = 1'b0;

  always_comb begin
    grant = 2'b00;
    if (req[PORT_CPU]) begin
      grant = port_onehot(1'b0);
    end else if (req[PORT_DMA]) begin
      grant = port_onehot(1'b1);
    end
  end
`else
  // ptr names the preferred port; a lone requester wins regardless of it,
  // and the pointer always moves away from whoever was granted.
  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr;
    case (req)
      2'b01:   grant = port_onehot(1'b0);
      2'b10:   grant = port_onehot(1'b1);
      2'b11:   grant = port_onehot(ptr);
      default: grant = 2'b00;
    endcase
    if (grant[PORT_CPU]) begin
      ptr_next = 1'b1;
    end else if (grant[PORT_DMA]) begin
      ptr_next = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async 16-bit SRAM between the CPU (port 0) and DMA (port 1).
// Option macro: SRAM_ARB_FIXED_PRIO_EN (port 0 fixed priority instead of round-robin).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              reset_in,

  input  logic              p0_valid,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [1:0]        p0_be,
  output logic              p0_ready,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,

  input  logic              p1_valid,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [1:0]        p1_be,
  output logic              p1_ready,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,

  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dat_write,
  input  logic [DATA_W-1:0] sram_dat_read,
  output logic              sram_dat_writeEnable,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,

  output logic [1:0]        dbg_state
);

  // Handshake: a request is transferred in the cycle where pN_valid and
  // pN_ready are both high; ready only rises in IDLE for the granted port.
  // Responses are single-cycle pulses with no backpressure.

  localparam logic [3:0] LAST_ACCESS = 4'(WAIT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              rr_ptr_q, rr_ptr_d;
  xfer_ctl_t         ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cs_n_q, cs_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              lb_n_q, lb_n_d;
  logic              ub_n_q, ub_n_d;
  logic              dat_oe_q, dat_oe_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0]        grant;
  logic              ptr_next;

  sram_arb_rr2 u_rr2 (
    .req      ({p1_valid, p0_valid}),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .ptr_next (ptr_next)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    ctl_d       = ctl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    p0_ready    = 1'b0;
    p1_ready    = 1'b0;
    cs_n_d      = STROBE_OFF;
    we_n_d      = STROBE_OFF;
    oe_n_d      = STROBE_OFF;
    lb_n_d      = STROBE_OFF;
    ub_n_d      = STROBE_OFF;
    dat_oe_d    = 1'b0;
    rsp_valid_d = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          p0_ready   = grant[PORT_CPU];
          p1_ready   = grant[PORT_DMA];
          rr_ptr_d   = ptr_next;
          ctl_d.port = grant[PORT_DMA];
          if (grant[PORT_DMA]) begin
            ctl_d.write = p1_write;
            ctl_d.be    = p1_be;
            addr_d      = p1_addr;
            wdata_d     = p1_wdata;
          end else begin
            ctl_d.write = p0_write;
            ctl_d.be    = p0_be;
            addr_d      = p0_addr;
            wdata_d     = p0_wdata;
          end
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_cnt_d = 4'd0;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (wait_cnt_q == LAST_ACCESS) begin
          // Bus has been settled for the whole access window; sample it now.
          if (!ctl_q.write) begin
            if (ctl_q.port) begin
              rdata1_d = sram_dat_read;
            end else begin
              rdata0_d = sram_dat_read;
            end
          end
          state_d = ST_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pin-side outputs are registered from the state being entered, so the
    // strobes line up with the state for the whole cycle.
    case (state_d)
      ST_SETUP: begin
        cs_n_d   = 1'b0;
        oe_n_d   = ctl_d.write;
        lb_n_d   = ~ctl_d.be[0];
        ub_n_d   = ~ctl_d.be[1];
        dat_oe_d = ctl_d.write;
      end
      ST_ACCESS: begin
        cs_n_d   = 1'b0;
        oe_n_d   = ctl_d.write;
        we_n_d   = ~ctl_d.write;
        lb_n_d   = ~ctl_d.be[0];
        ub_n_d   = ~ctl_d.be[1];
        dat_oe_d = ctl_d.write;
      end
      ST_HOLD: begin
        // we_n/oe_n released, chip select and data kept for hold time.
        cs_n_d      = 1'b0;
        lb_n_d      = ~ctl_d.be[0];
        ub_n_d      = ~ctl_d.be[1];
        dat_oe_d    = ctl_d.write;
        rsp_valid_d = port_onehot(ctl_d.port);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      rr_ptr_q    <= 1'(PORT_CPU);
      ctl_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_n_q      <= STROBE_OFF;
      we_n_q      <= STROBE_OFF;
      oe_n_q      <= STROBE_OFF;
      lb_n_q      <= STROBE_OFF;
      ub_n_q      <= STROBE_OFF;
      dat_oe_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      ctl_q       <= ctl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      dat_oe_q    <= dat_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign sram_addr            = addr_q;
  assign sram_dat_write       = wdata_q;
  assign sram_dat_writeEnable = dat_oe_q;
  assign sram_cs_n            = cs_n_q;
  assign sram_we_n            = we_n_q;
  assign sram_oe_n            = oe_n_q;
  assign sram_lb_n            = lb_n_q;
  assign sram_ub_n            = ub_n_q;
  assign p0_rsp_valid         = rsp_valid_q[PORT_CPU];
  assign p1_rsp_valid         = rsp_valid_q[PORT_DMA];
  assign p0_rsp_rdata         = rdata0_q;
  assign p1_rsp_rdata         = rdata1_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM device model, transaction-level reference model
// compared every cycle, directed scenarios and randomized two-port traffic.
module tb_sram_arbiter;

  localparam int W    = 2;
  localparam int TR_N = 20000;

  logic        CLK = 1'b0;
  logic        reset_in;
  logic        rst_x;
  logic        x_valid;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        p0_valid, p0_write, p1_valid, p1_write;
  logic [17:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [1:0]  p0_be, p1_be;
  logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid;
  logic [15:0] p0_rsp_rdata, p1_rsp_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_dat_write, sram_dat_read;
  logic        sram_dat_writeEnable, sram_cs_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n;
  logic [1:0]  dbg_state;

  logic [15:0] dev_mem [0:262143];
  logic [15:0] exp_mem [0:262143];

  bit tr_rdy0 [TR_N], tr_rdy1 [TR_N], tr_rsp0 [TR_N], tr_rsp1 [TR_N];
  bit tr_cs [TR_N], tr_we [TR_N], tr_oe [TR_N], tr_wen [TR_N], tr_lb [TR_N], tr_ub [TR_N];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .CLK(CLK), .reset_in(reset_in),
    .p0_valid(p0_valid), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_be(p0_be), .p0_ready(p0_ready), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_valid(p1_valid), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_be(p1_be), .p1_ready(p1_ready), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .sram_addr(sram_addr), .sram_dat_write(sram_dat_write), .sram_dat_read(sram_dat_read),
    .sram_dat_writeEnable(sram_dat_writeEnable), .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .dbg_state(dbg_state)
  );

  // Secondary instances with extreme wait-state counts, reading back-to-back.
  wire [1:0]  x_rdy0, x_rdy1, x_rsp0, x_rsp1, x_wen, x_cs, x_we, x_oe, x_lb, x_ub;
  wire [15:0] x_rdata0 [2];
  wire [15:0] x_rdata1 [2];
  wire [15:0] x_dw [2];
  wire [17:0] x_addr [2];
  wire [1:0]  x_dbg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_x
    localparam int WX = (gi == 0) ? 1 : 15;
    sram_arbiter #(.WAIT_CYCLES(WX)) u_x (
      .CLK(CLK), .reset_in(rst_x),
      .p0_valid(x_valid), .p0_write(1'b0), .p0_addr(18'h00042), .p0_wdata(16'h0000),
      .p0_be(2'b11), .p0_ready(x_rdy0[gi]), .p0_rsp_valid(x_rsp0[gi]), .p0_rsp_rdata(x_rdata0[gi]),
      .p1_valid(1'b0), .p1_write(1'b0), .p1_addr(18'h00000), .p1_wdata(16'h0000),
      .p1_be(2'b00), .p1_ready(x_rdy1[gi]), .p1_rsp_valid(x_rsp1[gi]), .p1_rsp_rdata(x_rdata1[gi]),
      .sram_addr(x_addr[gi]), .sram_dat_write(x_dw[gi]), .sram_dat_read(16'h1111),
      .sram_dat_writeEnable(x_wen[gi]), .sram_cs_n(x_cs[gi]), .sram_we_n(x_we[gi]),
      .sram_oe_n(x_oe[gi]), .sram_lb_n(x_lb[gi]), .sram_ub_n(x_ub[gi]), .dbg_state(x_dbg[gi])
    );
  end

  // Async SRAM device: combinational read, byte-lane write while we_n is low.
  assign sram_dat_read = (!sram_cs_n && !sram_oe_n) ? dev_mem[sram_addr] : 16'h0000;
  always @(negedge CLK) begin
    if (!sram_cs_n && !sram_we_n && sram_dat_writeEnable) begin
      if (!sram_lb_n) dev_mem[sram_addr][7:0] <= sram_dat_write[7:0];
      if (!sram_ub_n) dev_mem[sram_addr][15:8] <= sram_dat_write[15:8];
    end
  end

  function automatic logic [15:0] init_word(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // ph counts cycles since the accepting cycle (0 = no transfer in progress).
  int          ph = 0;
  logic        m_ptr, m_port, m_write;
  logic [1:0]  m_be;
  logic [17:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata [2];

  function automatic int pick_port();
`ifdef SRAM_ARB_FIXED_PRIO_EN
    return p0_valid ? 0 : 1;
`else
    if (p0_valid && p1_valid) return int'(m_ptr);
    return p0_valid ? 0 : 1;
`endif
  endfunction

  always @(negedge CLK) begin : model_cmp
    logic [1:0] e_rdy, e_rsp;
    logic e_cs, e_we, e_oe, e_lb, e_ub, e_wen;
    int win;
    bit acc;
    e_rdy = 2'b00; e_rsp = 2'b00; e_cs = 1; e_we = 1; e_oe = 1; e_lb = 1; e_ub = 1; e_wen = 0;
    acc = 0; win = 0;
    if (reset_in) begin
      ph = 0; m_ptr = 0; m_port = 0; m_write = 0; m_be = 0; m_addr = 0; m_wdata = 0;
      m_rdata[0] = 0; m_rdata[1] = 0;
    end else if (ph == 0) begin
      if (p0_valid || p1_valid) begin
        acc = 1; win = pick_port(); e_rdy[win] = 1'b1;
      end
    end else begin
      e_cs = 0; e_lb = ~m_be[0]; e_ub = ~m_be[1]; e_wen = m_write;
      if (ph <= W + 1) e_oe = m_write;
      if (ph >= 2 && ph <= W + 1) e_we = ~m_write;
      if (ph == W + 2) begin
        e_rsp[m_port] = 1'b1;
        if (!m_write) m_rdata[m_port] = exp_mem[m_addr];
        else begin
          if (m_be[0]) exp_mem[m_addr][7:0] = m_wdata[7:0];
          if (m_be[1]) exp_mem[m_addr][15:8] = m_wdata[15:8];
        end
      end
    end
    if (cyc < TR_N) begin
      tr_rdy0[cyc] = p0_ready; tr_rdy1[cyc] = p1_ready; tr_rsp0[cyc] = p0_rsp_valid;
      tr_rsp1[cyc] = p1_rsp_valid; tr_cs[cyc] = sram_cs_n; tr_we[cyc] = sram_we_n;
      tr_oe[cyc] = sram_oe_n; tr_wen[cyc] = sram_dat_writeEnable;
      tr_lb[cyc] = sram_lb_n; tr_ub[cyc] = sram_ub_n;
    end
    chk("p0_ready", p0_ready, e_rdy[0]);
    chk("p1_ready", p1_ready, e_rdy[1]);
    chk("cs_n", sram_cs_n, e_cs);
    chk("we_n", sram_we_n, e_we);
    chk("oe_n", sram_oe_n, e_oe);
    chk("lb_n", sram_lb_n, e_lb);
    chk("ub_n", sram_ub_n, e_ub);
    chk("dat_we", sram_dat_writeEnable, e_wen);
    chk("p0_rsp_valid", p0_rsp_valid, e_rsp[0]);
    chk("p1_rsp_valid", p1_rsp_valid, e_rsp[1]);
    chk("p0_rsp_rdata", p0_rsp_rdata, m_rdata[0]);
    chk("p1_rsp_rdata", p1_rsp_rdata, m_rdata[1]);
    chk("sram_addr", sram_addr, m_addr);
    chk("sram_dat_write", sram_dat_write, m_wdata);
    if (!reset_in) begin
      if (acc) begin
        m_port = win[0];
        m_write = win[0] ? p1_write : p0_write;
        m_be    = win[0] ? p1_be : p0_be;
        m_addr  = win[0] ? p1_addr : p0_addr;
        m_wdata = win[0] ? p1_wdata : p0_wdata;
        m_ptr   = ~win[0];
        ph = 1;
      end else if (ph == W + 2) ph = 0;
      else if (ph > 0) ph++;
    end
  end

  // Response spacing of the WAIT_CYCLES=1 and =15 instances.
  int last_x [2] = '{-1, -1};
  int n_x [2] = '{0, 0};
  always @(negedge CLK) begin
    if (!rst_x) begin
      for (int g = 0; g < 2; g++) begin
        if (x_rsp0[g]) begin
          if (last_x[g] >= 0)
            chk(g == 0 ? "w1_spacing" : "w15_spacing", cyc - last_x[g], g == 0 ? 4 : 18);
          chk("wx_rdata", x_rdata0[g], 16'h1111);
          last_x[g] = cyc;
          n_x[g]++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_req(input int port, input logic wr, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] be, output int t_acc);
    if (port == 0) begin
      p0_write = wr; p0_addr = a; p0_wdata = d; p0_be = be; p0_valid = 1'b1;
    end else begin
      p1_write = wr; p1_addr = a; p1_wdata = d; p1_be = be; p1_valid = 1'b1;
    end
    t_acc = -1;
    for (int i = 0; i < 200 && t_acc < 0; i++) begin
      @(negedge CLK);
      if ((port == 0 && p0_ready) || (port == 1 && p1_ready)) t_acc = cyc;
    end
    if (t_acc < 0) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: port %0d got no ready, expected ready within 200 cycles", port);
    end
    @(posedge CLK); #1;
    if (port == 0) p0_valid = 1'b0; else p1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic rand_port(input int port, input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      idle($urandom_range(0, 7));
      do_req(port, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 63)), 16'($urandom),
             2'($urandom_range(0, 3)), t);
    end
  endtask

  int t, t0, t1, c0, nrsp;
  int q_port[$];
  int q_cyc[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 50000 cycles");
    $fatal(1);
  end

  initial begin
    reset_in = 1; rst_x = 1; x_valid = 0;
    p0_valid = 0; p0_write = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
    p1_valid = 0; p1_write = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
    for (int i = 0; i < 262144; i++) begin
      dev_mem[i] = init_word(18'(i));
      exp_mem[i] = init_word(18'(i));
    end
    dev_mem[18'h12345] = 16'hBEEF; exp_mem[18'h12345] = 16'hBEEF;
    dev_mem[18'h00010] = 16'h1234; exp_mem[18'h00010] = 16'h1234;
    dev_mem[18'h00030] = 16'h0F0F; exp_mem[18'h00030] = 16'h0F0F;
    repeat (3) @(posedge CLK);
    #1;
    reset_in = 0; rst_x = 0; x_valid = 1;
    idle(1);

    // Single read on port 0.
    do_req(0, 1'b0, 18'h12345, 16'h0000, 2'b11, t);
    idle(6);
    chk("rd_ready_at_T", tr_rdy0[t], 1);
    chk("rd_oe_window", {tr_oe[t], tr_oe[t+1], tr_oe[t+2], tr_oe[t+3], tr_oe[t+4]}, 5'b10001);
    chk("rd_rsp_at_T4", {tr_rsp0[t+3], tr_rsp0[t+4], tr_rsp0[t+5]}, 3'b010);
    chk("rd_data", p0_rsp_rdata, 16'hBEEF);

    // Lower-lane write on port 1.
    do_req(1, 1'b1, 18'h00010, 16'hA55A, 2'b01, t);
    idle(6);
    chk("wr_lanes", {tr_lb[t+1], tr_ub[t+1]}, 2'b01);
    chk("wr_we_window", {tr_we[t+1], tr_we[t+2], tr_we[t+3], tr_we[t+4]}, 4'b1001);
    chk("wr_oe_window", {tr_wen[t], tr_wen[t+1], tr_wen[t+2], tr_wen[t+3], tr_wen[t+4], tr_wen[t+5]}, 6'b011110);
    chk("wr_rsp", tr_rsp1[t+4], 1);
    chk("wr_mem", dev_mem[18'h00010], 16'h125A);

    // Contention: both ports requesting continuously.
    c0 = cyc;
    fork
`ifdef SRAM_ARB_FIXED_PRIO_EN
      begin repeat (6) do_req(0, 1'b0, 18'h00001, 16'h0, 2'b11, t0); end
      begin repeat (1) do_req(1, 1'b0, 18'h00002, 16'h0, 2'b11, t1); end
`else
      begin repeat (3) do_req(0, 1'b0, 18'h00001, 16'h0, 2'b11, t0); end
      begin repeat (3) do_req(1, 1'b0, 18'h00002, 16'h0, 2'b11, t1); end
`endif
    join
    idle(6);
    for (int c = c0; c < cyc && c < TR_N; c++) begin
      if (tr_rdy0[c]) begin q_port.push_back(0); q_cyc.push_back(c); end
      if (tr_rdy1[c]) begin q_port.push_back(1); q_cyc.push_back(c); end
    end
    chk("cont_grant_count", q_port.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      chk("cont_grant_port", q_port.size() > i ? q_port[i] : -1, 0);
`else
      chk("cont_grant_port", q_port.size() > i ? q_port[i] : -1, i % 2);
`endif
      if (i > 0) chk("cont_grant_gap", q_cyc.size() > i ? q_cyc[i] - q_cyc[i-1] : -1, 5);
    end

    // Write with no byte lanes enabled.
    do_req(0, 1'b1, 18'h00030, 16'hDEAD, 2'b00, t);
    idle(6);
    chk("be0_lanes", {tr_lb[t+1], tr_ub[t+1], tr_lb[t+3], tr_ub[t+3]}, 4'b1111);
    chk("be0_cs_window", {tr_cs[t+1], tr_cs[t+2], tr_cs[t+3], tr_cs[t+4], tr_cs[t+5]}, 5'b00001);
    chk("be0_we_window", {tr_we[t+1], tr_we[t+2], tr_we[t+3], tr_we[t+4]}, 4'b1001);
    chk("be0_rsp", tr_rsp0[t+4], 1);
    chk("be0_mem", dev_mem[18'h00030], 16'h0F0F);

    // Reset during ACCESS of a write.
    do_req(0, 1'b1, 18'h00020, 16'hFFFF, 2'b11, t);
    idle(1);
    chk("rst_pre_we", sram_we_n, 0);
    reset_in = 1;
    #1;
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_cs_n", sram_cs_n, 1);
    chk("rst_dat_we", sram_dat_writeEnable, 0);
    idle(2);
    reset_in = 0;
    idle(8);
    nrsp = 0;
    for (int c = t; c < cyc && c < TR_N; c++) nrsp += int'(tr_rsp0[c]) + int'(tr_rsp1[c]);
    chk("rst_no_rsp", nrsp, 0);
    chk("rst_mem", dev_mem[18'h00020], init_word(18'h00020));
    do_req(1, 1'b0, 18'h12345, 16'h0000, 2'b10, t);
    idle(6);
    chk("post_rst_rsp", tr_rsp1[t+4], 1);
    chk("post_rst_data", p1_rsp_rdata, 16'hBEEF);

    // Randomized traffic on both ports.
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    idle(40);

    chk("w1_seen", n_x[0] >= 3, 1);
    chk("w15_seen", n_x[1] >= 3, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
